// File: rtl/mbus_read_ctl.sv
`timescale 1ns/1ps
// MBUS read controller: arbitrates two read requesters, runs one MBUS read cycle at a time.
// Latency: START one cycle after accept; each MBUS word is returned one cycle after capture.
// Backpressure: requesters see ready only in IDLE; responses are unthrottled one-cycle pulses.
module mbus_read_ctl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [21:0] req0_adr,
    input  logic [3:0]  req0_rq,
    input  logic        req1_valid,
    input  logic [21:0] req1_adr,
    input  logic [3:0]  req1_rq,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [35:0] resp_data,
    output logic [1:0]  resp_wo,
    output logic        resp_last,
    output logic        resp_nxm,
    output logic        resp_par_err,
    output logic        mb_start,
    output logic        mb_adr_hold,
    output logic [21:0] mb_adr,
    output logic [3:0]  mb_rq,
    input  logic        mb_ackn,
    input  logic        mb_in_valid,
    input  logic [35:0] mb_d,
    input  logic        mb_par
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, XFER} state_t;

    state_t        state;
    logic          last_gnt;      // 1: req1 was granted most recently, so req0 wins a tie
    logic [21:0]   adr_q;
    logic [3:0]    rq_q;
    logic          id_q;
    logic [1:0]    wo_q;
    logic [2:0]    remaining;
    logic [CW-1:0] tmo_cnt;

    logic          pick1;
    logic          accept;
    logic [21:0]   acc_adr;
    logic [3:0]    acc_rq;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    assign mb_adr = adr_q;
    assign mb_rq  = rq_q;

    // Round-robin arbitration; ready only while idle and out of reset
    always_comb begin
        pick1      = req1_valid && (!req0_valid || !last_gnt);
        req0_ready = (state == IDLE) && !reset && req0_valid && !pick1;
        req1_ready = (state == IDLE) && !reset && pick1;
        accept     = req0_ready || req1_ready;
        acc_adr    = pick1 ? req1_adr : req0_adr;
        acc_rq     = pick1 ? req1_rq  : req0_rq;
    end

    // Request FSM: latch on accept, run START/XFER, return words or an NXM abort
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_gnt     <= 1'b1;
            adr_q        <= '0;
            rq_q         <= '0;
            id_q         <= 1'b0;
            wo_q         <= '0;
            remaining    <= '0;
            tmo_cnt      <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= 1'b0;
            resp_data    <= '0;
            resp_wo      <= '0;
            resp_last    <= 1'b0;
            resp_nxm     <= 1'b0;
            resp_par_err <= 1'b0;
            mb_start     <= 1'b0;
            mb_adr_hold  <= 1'b0;
        end else begin
            resp_valid   <= 1'b0;
            resp_last    <= 1'b0;
            resp_nxm     <= 1'b0;
            resp_par_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_gnt <= pick1;
                        // An empty word mask is consumed without touching the bus
                        if (acc_rq != 4'b0000) begin
                            adr_q       <= acc_adr;
                            rq_q        <= acc_rq;
                            id_q        <= pick1;
                            wo_q        <= acc_adr[1:0];
                            remaining   <= popcount4(acc_rq);
                            tmo_cnt     <= '0;
                            mb_start    <= 1'b1;
                            mb_adr_hold <= 1'b1;
                            state       <= START;
                        end
                    end
                end
                START, XFER: begin
                    if (mb_in_valid) begin
                        // A word may arrive together with the first ACKN
                        resp_valid   <= 1'b1;
                        resp_id      <= id_q;
                        resp_data    <= mb_d;
                        resp_wo      <= wo_q;
                        resp_par_err <= (^mb_d) != mb_par;
                        resp_last    <= (remaining == 3'd1);
                        wo_q         <= wo_q + 2'd1;
                        remaining    <= remaining - 3'd1;
                        tmo_cnt      <= '0;
                        if (remaining == 3'd1) begin
                            state       <= IDLE;
                            mb_start    <= 1'b0;
                            mb_adr_hold <= 1'b0;
                        end else if (mb_ackn) begin
                            state    <= XFER;
                            mb_start <= 1'b0;
                        end
                    end else if (mb_ackn) begin
                        tmo_cnt  <= '0;
                        state    <= XFER;
                        mb_start <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // No memory answered: abort with a single zero-data NXM response
                        resp_valid  <= 1'b1;
                        resp_id     <= id_q;
                        resp_data   <= '0;
                        resp_wo     <= wo_q;
                        resp_last   <= 1'b1;
                        resp_nxm    <= 1'b1;
                        state       <= IDLE;
                        mb_start    <= 1'b0;
                        mb_adr_hold <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mbus_read_ctl.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for mbus_read_ctl acting as both requesters and MBUS memory.
// Expected responses are queued as stimulus is driven; a negedge monitor pops and compares.
// Memory timing, stalls, parity errors and resets are chosen per transaction.
module tb_mbus_read_ctl;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [21:0] req0_adr, req1_adr;
    logic [3:0]  req0_rq, req1_rq;
    logic        req0_ready, req1_ready;
    logic        resp_valid, resp_id, resp_last, resp_nxm, resp_par_err;
    logic [35:0] resp_data;
    logic [1:0]  resp_wo;
    logic        mb_start, mb_adr_hold;
    logic [21:0] mb_adr;
    logic [3:0]  mb_rq;
    logic        mb_ackn, mb_in_valid, mb_par;
    logic [35:0] mb_d;

    always #5 clk = ~clk;

    mbus_read_ctl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_adr(req0_adr), .req0_rq(req0_rq),
        .req1_valid(req1_valid), .req1_adr(req1_adr), .req1_rq(req1_rq),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .resp_wo(resp_wo), .resp_last(resp_last), .resp_nxm(resp_nxm),
        .resp_par_err(resp_par_err),
        .mb_start(mb_start), .mb_adr_hold(mb_adr_hold), .mb_adr(mb_adr), .mb_rq(mb_rq),
        .mb_ackn(mb_ackn), .mb_in_valid(mb_in_valid), .mb_d(mb_d), .mb_par(mb_par)
    );

    typedef struct {
        logic        id;
        logic [35:0] data;
        logic [1:0]  wo;
        logic        last;
        logic        nxm;
        logic        perr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          rr_last = 1'b1;      // requester granted most recently
    logic [21:0] r_adr[2];
    logic [3:0]  r_rq[2];
    bit          m_id;
    int          m_k, m_n;
    logic [1:0]  m_wo0;
    bit          tight;               // memory answers every cycle with no gaps
    bit          perr_rand;
    logic [3:0]  perr_mask;           // bit k: corrupt parity of k-th word
    bit          v0, v1;
    int          md0, md1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: every response pulse must match the head of the queue
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", resp_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_id", resp_id, mon_e.id);
                check("resp_data", resp_data, mon_e.data);
                if (!mon_e.nxm) check("resp_wo", resp_wo, mon_e.wo);
                check("resp_last", resp_last, mon_e.last);
                check("resp_nxm", resp_nxm, mon_e.nxm);
                check("resp_par_err", resp_par_err, mon_e.perr);
            end
        end
    end

    // One MBUS cycle from the memory side; a driven word queues its expected response
    task automatic cyc(input bit a, input bit v);
        logic [63:0] r;
        bit          pe;
        exp_t        e;
        mb_ackn     = a;
        mb_in_valid = v;
        if (v) begin
            r      = {$urandom(), $urandom()};
            pe     = perr_rand ? ($urandom_range(0, 3) == 0) : perr_mask[m_k];
            mb_d   = r[35:0];
            mb_par = (^r[35:0]) ^ pe;
            e.id   = m_id;
            e.data = r[35:0];
            e.wo   = m_wo0 + 2'(m_k);
            e.last = (m_k == m_n - 1);
            e.nxm  = 1'b0;
            e.perr = pe;
            exp_q.push_back(e);
            m_k++;
        end
        @(negedge clk);
    endtask

    // mode 0: full transfer; 1: stall after some words; 2: never ACKN; 3: reset after 2 words
    task automatic run_plan(input bit id, input logic [21:0] adr, input logic [3:0] rq, input int mode);
        int   d, g, stop, starts;
        bit   acked;
        exp_t e;
        m_id  = id;
        m_k   = 0;
        m_n   = $countones(rq);
        m_wo0 = adr[1:0];
        check("mb_start_on_accept", mb_start, 1);
        check("mb_adr_hold_start", mb_adr_hold, 1);
        check("mb_adr", mb_adr, adr);
        check("mb_rq", mb_rq, rq);
        d     = tight ? 0 : $urandom_range(0, 3);
        stop  = (mode == 1) ? $urandom_range(0, m_n - 1) : (mode == 3) ? 2 : m_n;
        acked = 1'b0;
        if (mode != 2) begin
            for (int i = 0; i < d; i++) cyc(0, 0);
            for (int w = 0; w < stop; w++) begin
                g = tight ? 0 : $urandom_range(0, 2);
                for (int i = 0; i < g; i++) begin
                    cyc(!acked, 0);
                    acked = 1'b1;
                end
                cyc(!acked, 1);
                acked = 1'b1;
            end
            if (!acked) cyc(1, 0);
        end
        if (mode == 3) begin
            reset       = 1'b1;
            req0_valid  = 1'b1;
            mb_ackn     = 1'b0;
            mb_in_valid = 1'b1;
            mb_d        = 36'h123456789;
            mb_par      = 1'b0;
            @(negedge clk);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_req0_ready", req0_ready, 0);
            check("rst_mb_start", mb_start, 0);
            check("rst_mb_adr_hold", mb_adr_hold, 0);
            check("rst_mb_adr", mb_adr, 0);
            check("rst_mb_rq", mb_rq, 0);
            check("rst_resp_data", resp_data, 0);
            check("rst_resp_last", resp_last, 0);
            req0_valid  = 1'b0;
            mb_in_valid = 1'b0;
            @(negedge clk);
            reset   = 1'b0;
            rr_last = 1'b1;
        end else if (mode != 0) begin
            e.id = id; e.data = '0; e.wo = '0; e.last = 1'b1; e.nxm = 1'b1; e.perr = 1'b0;
            exp_q.push_back(e);
            starts = 0;
            for (int i = 0; i < TMO; i++) begin
                if (i == 0) check("mb_adr_hold_wait", mb_adr_hold, 1);
                starts += int'(mb_start);
                cyc(0, 0);
            end
            check("mb_start_cycles", starts, (mode == 2) ? TMO : 0);
            check("mb_start_after_nxm", mb_start, 0);
            check("mb_adr_hold_idle", mb_adr_hold, 0);
        end
    endtask

    // Present requests; the model predicts the round-robin winner, which must be ready at once
    task automatic present(input bit p0, input bit p1, input int mode0, input int mode1);
        bit          pend0, pend1;
        int          w;
        logic [63:0] r;
        pend0 = p0;
        pend1 = p1;
        while (pend0 || pend1) begin
            req0_valid  = pend0;
            req1_valid  = pend1;
            req0_adr    = r_adr[0];
            req0_rq     = r_rq[0];
            req1_adr    = r_adr[1];
            req1_rq     = r_rq[1];
            r           = {$urandom(), $urandom()};
            mb_ackn     = 1'b0;
            mb_in_valid = r[63];      // stray data while idle must be ignored
            mb_d        = r[35:0];
            mb_par      = r[40];
            #1;
            w = (pend0 && pend1) ? (rr_last ? 0 : 1) : (pend1 ? 1 : 0);
            check("req0_ready", req0_ready, w == 0);
            check("req1_ready", req1_ready, w == 1);
            @(negedge clk);
            rr_last = (w == 1);
            if (w == 0) pend0 = 1'b0; else pend1 = 1'b0;
            req0_valid  = pend0;
            req1_valid  = pend1;
            mb_in_valid = 1'b0;
            if (r_rq[w] != 4'b0000) run_plan(w[0], r_adr[w], r_rq[w], (w == 1) ? mode1 : mode0);
        end
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        mb_ackn     = 1'b0;
        mb_in_valid = 1'b0;
    endtask

    function automatic int pick_mode();
        int r;
        r = $urandom_range(0, 9);
        return (r == 0) ? 1 : (r == 1) ? 2 : 0;
    endfunction

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_adr = '0; req1_adr = '0; req0_rq = 4'b1111; req1_rq = '0;
        mb_ackn = 1'b0; mb_in_valid = 1'b0; mb_d = '0; mb_par = 1'b0;
        tight = 1'b1; perr_rand = 1'b0; perr_mask = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset_req0_ready", req0_ready, 0);
        check("reset_resp_valid", resp_valid, 0);
        check("reset_mb_start", mb_start, 0);
        check("reset_mb_adr_hold", mb_adr_hold, 0);
        check("reset_mb_adr", mb_adr, 0);
        check("reset_mb_rq", mb_rq, 0);
        check("reset_resp_data", resp_data, 0);
        req0_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Tie from reset twice: req0 wins first each time, then req1
        r_adr[0] = 22'o1002; r_rq[0] = 4'b1111;
        r_adr[1] = 22'o7777; r_rq[1] = 4'b0111;
        present(1, 1, 0, 0);
        present(1, 1, 0, 0);
        // Wrapping word offsets 2,3,0,1
        present(1, 0, 0, 0);
        // Sparse mask: two words only
        r_rq[0] = 4'b1010;
        present(1, 0, 0, 0);
        // No ACKN: timeout abort
        r_rq[0] = 4'b1111;
        present(1, 0, 2, 0);
        // Parity error on the third word only
        perr_mask = 4'b0100;
        present(1, 0, 0, 0);
        perr_mask = 4'b0000;
        // Empty mask is consumed silently, next request still served
        r_rq[1] = 4'b0000;
        present(0, 1, 0, 0);
        r_rq[0] = 4'b0110; r_adr[0] = 22'o3;
        present(1, 0, 0, 0);
        // Reset in mid-transfer, then a normal request
        r_rq[0] = 4'b1111;
        present(1, 0, 3, 0);
        present(1, 0, 0, 0);

        tight = 1'b0;
        perr_rand = 1'b1;
        repeat (60) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            r_adr[0] = 22'($urandom());
            r_adr[1] = 22'($urandom());
            r_rq[0]  = 4'($urandom_range(0, 15));
            r_rq[1]  = 4'($urandom_range(0, 15));
            md0 = pick_mode();
            md1 = pick_mode();
            present(v0, v1, md0, md1);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
